// File: rtl/legv8_pkg.sv
// Shared encodings for the multicycle LEGv8 control path: FSM states, opcode
// patterns, ALUOp codes and datapath mux selects.
package legv8_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADDR = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXEC_R  = 4'd6,
    ST_RWB     = 4'd7,
    ST_CBZ     = 4'd8,
    ST_B       = 4'd9
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b10110100;
  localparam logic [5:0]  OP_B_PFX   = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_R     = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_BR     = 2'b10;

  // Exactly one field is set for any opcode.
  typedef struct packed {
    logic r;
    logic ld;
    logic st;
    logic cbz;
    logic b;
    logic ill;
  } opclass_t;

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode classifier: maps the 11-bit opcode to a one-hot
// instruction class, with everything unrecognised flagged illegal.
module opcode_class_decode
  import legv8_pkg::*;
(
  input  logic [10:0] Opcode,
  output opclass_t    cls
);

  always_comb begin
    cls = '0;
    if (Opcode == OP_ADD || Opcode == OP_SUB || Opcode == OP_AND || Opcode == OP_ORR)
      cls.r = 1'b1;
    else if (Opcode == OP_LDUR)
      cls.ld = 1'b1;
    else if (Opcode == OP_STUR)
      cls.st = 1'b1;
    else if (Opcode[10:3] == OP_CBZ_PFX)
      cls.cbz = 1'b1;
    else if (Opcode[10:5] == OP_B_PFX)
      cls.b = 1'b1;
    else
      cls.ill = 1'b1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle LEGv8 datapath, with memory wait states,
// a bounded memory wait (BusError) and an illegal-opcode trap.
module multicycle_control
  import legv8_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [1:0]  ALUOp,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic [1:0]  PCSource,
  output logic        PCEn,
  output logic        InstrDone,
  output logic        Illegal,
  output logic        BusError,
  output logic [3:0]  State
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          state, state_next;
  logic [TO_W-1:0] wcnt, wcnt_next;
  opclass_t        cls;
  logic            mem_state, to_hit;
  logic            pcwrite, pcwritecond;

  opcode_class_decode u_dec (
    .Opcode (Opcode),
    .cls    (cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      wcnt  <= '0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
    end
  end

  // A timeout fires only when memory is still not ready on the last allowed cycle.
  assign mem_state = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
  assign to_hit    = mem_state && !MemReady && (wcnt == TO_LAST);

  always_comb begin
    state_next  = state;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_REG;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    Reg2Loc     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    PCSource    = PCSRC_ALU;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    InstrDone   = 1'b0;
    Illegal     = 1'b0;
    BusError    = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (MemReady) begin
            IRWrite    = 1'b1;
            pcwrite    = 1'b1;
            state_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          ALUSrcB = SRCB_IMM2;
          Reg2Loc = cls.st | cls.cbz;
          if (cls.ld || cls.st) state_next = ST_MEMADDR;
          else if (cls.r)       state_next = ST_EXEC_R;
          else if (cls.cbz)     state_next = ST_CBZ;
          else if (cls.b)       state_next = ST_B;
          else begin
            Illegal    = 1'b1;
            state_next = ST_FETCH;
          end
        end
        ST_MEMADDR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          Reg2Loc    = cls.st;
          state_next = cls.st ? ST_MEMWR : ST_MEMRD;
        end
        ST_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (MemReady) state_next = ST_MEMWB;
        end
        ST_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          InstrDone  = 1'b1;
          state_next = ST_FETCH;
        end
        ST_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          Reg2Loc  = 1'b1;
          if (MemReady) begin
            InstrDone  = 1'b1;
            state_next = ST_FETCH;
          end
        end
        ST_EXEC_R: begin
          ALUSrcA    = 1'b1;
          ALUOp      = ALUOP_R;
          state_next = ST_RWB;
        end
        ST_RWB: begin
          RegWrite   = 1'b1;
          InstrDone  = 1'b1;
          state_next = ST_FETCH;
        end
        ST_CBZ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALUOP_PASSB;
          Reg2Loc     = 1'b1;
          pcwritecond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
          InstrDone   = 1'b1;
          state_next  = ST_FETCH;
        end
        ST_B: begin
          pcwrite    = 1'b1;
          PCSource   = PCSRC_BR;
          InstrDone  = 1'b1;
          state_next = ST_FETCH;
        end
        default: state_next = ST_FETCH;
      endcase
      if (to_hit) begin
        BusError   = 1'b1;
        state_next = ST_FETCH;
      end
    end
  end

  // Counter restarts on every state change and after a timeout retry of FETCH.
  always_comb begin
    wcnt_next = wcnt;
    if (to_hit || (state_next != state))
      wcnt_next = '0;
    else if (mem_state && !MemReady)
      wcnt_next = wcnt + TO_W'(1);
  end

  assign PCEn  = pcwrite | (pcwritecond & Zero);
  assign State = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: an instruction-level model expands
// each directed vector into the expected per-cycle control trace.
module tb_multicycle_control;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] Opcode = '0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic [1:0]  ALUOp, ALUSrcB, PCSource;
  logic        ALUSrcA, IorD, MemRead, MemWrite, IRWrite, Reg2Loc, RegWrite, MemtoReg;
  logic        PCEn, InstrDone, Illegal, BusError;
  logic [3:0]  State;

  multicycle_control #(.MEM_TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .Reg2Loc(Reg2Loc),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .PCSource(PCSource), .PCEn(PCEn),
    .InstrDone(InstrDone), .Illegal(Illegal), .BusError(BusError), .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       iord, mrd, mwr, irw, r2l, rw, m2r;
    logic [1:0] pcsrc;
    logic       pcen, done, ill, berr;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic        chk_st;
    logic [10:0] op;
    logic        mr;
    logic        z;
    out_t        e;
  } vec_t;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDI = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] BR   = 11'b00010111111;
  localparam logic [10:0] ILL  = 11'b01010101010;
  localparam logic [10:0] JUNK = 11'b11111111111;

  vec_t  q[$];
  int    nvec = 0, nbad = 0;
  string tag;
  int    cyc, done_at, berr_at, ill_cnt, irw_cnt, rw_cnt, mw_cnt;
  logic [31:0] sseq;

  // Instruction class by the architectural opcode rules: 0 R,1 LD,2 ST,3 CBZ,4 B,5 illegal.
  function automatic int classify(input logic [10:0] op);
    if (op == ADD || op == SUB || op == ANDI || op == ORR) return 0;
    if (op == LDUR) return 1;
    if (op == STUR) return 2;
    if (op[10:3] == 8'hB4) return 3;
    if (op[10:5] == 6'b000101) return 4;
    return 5;
  endfunction

  function automatic vec_t nv(input logic [10:0] op, input logic z, input logic mr,
                              input logic [3:0] st);
    vec_t v = '0;
    v.op = op; v.z = z; v.mr = mr; v.chk_st = 1'b1; v.e.st = st;
    return v;
  endfunction

  function automatic vec_t rv(input logic [10:0] op, input logic chk);
    vec_t v = '0;
    v.rst = 1'b1; v.op = op; v.chk_st = chk;
    return v;
  endfunction

  // One memory access of the given kind, ready after w idle cycles or timing out.
  task automatic mem_access(input logic [10:0] op, input logic z, input int w,
                            input int kind, output bit ok);
    vec_t v;
    ok = 1'b0;
    for (int i = 0; i < TO; i++) begin
      v = nv(op, z, (i == w), (kind == 0) ? 4'd0 : (kind == 1) ? 4'd3 : 4'd5);
      if (kind == 0) begin
        v.e.mrd = 1'b1; v.e.srcb = 2'b01; v.e.irw = v.mr; v.e.pcen = v.mr;
      end else if (kind == 1) begin
        v.e.mrd = 1'b1; v.e.iord = 1'b1;
      end else begin
        v.e.mwr = 1'b1; v.e.iord = 1'b1; v.e.r2l = 1'b1; v.e.done = v.mr;
      end
      if (!v.mr && i == TO - 1) v.e.berr = 1'b1;
      q.push_back(v);
      if (v.mr) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  // Expected trace of one instruction: fetch waits fw cycles, data access waits mw.
  task automatic add_instr(input logic [10:0] op, input logic z, input int fw, input int mw);
    vec_t v;
    bit   ok;
    int   c = classify(op);
    mem_access(JUNK, z, fw, 0, ok);
    if (!ok) return;
    v = nv(op, z, 1'b1, 4'd1);
    v.e.srcb = 2'b11; v.e.r2l = (c == 2 || c == 3); v.e.ill = (c == 5);
    q.push_back(v);
    case (c)
      0: begin
        v = nv(op, z, 1'b1, 4'd6); v.e.srca = 1'b1; v.e.aluop = 2'b10; q.push_back(v);
        v = nv(op, z, 1'b1, 4'd7); v.e.rw = 1'b1; v.e.done = 1'b1; q.push_back(v);
      end
      1, 2: begin
        v = nv(op, z, 1'b1, 4'd2); v.e.srca = 1'b1; v.e.srcb = 2'b10; v.e.r2l = (c == 2);
        q.push_back(v);
        mem_access(op, z, mw, c, ok);
        if (ok && c == 1) begin
          v = nv(op, z, 1'b1, 4'd4); v.e.rw = 1'b1; v.e.m2r = 1'b1; v.e.done = 1'b1;
          q.push_back(v);
        end
      end
      3: begin
        v = nv(op, z, 1'b1, 4'd8); v.e.srca = 1'b1; v.e.aluop = 2'b01; v.e.r2l = 1'b1;
        v.e.pcsrc = 2'b01; v.e.pcen = z; v.e.done = 1'b1; q.push_back(v);
      end
      4: begin
        v = nv(op, z, 1'b1, 4'd9); v.e.pcsrc = 2'b10; v.e.pcen = 1'b1; v.e.done = 1'b1;
        q.push_back(v);
      end
      default: ;
    endcase
  endtask

  task automatic clr_stats(input string name);
    tag = name; cyc = 0; done_at = 0; berr_at = 0;
    ill_cnt = 0; irw_cnt = 0; rw_cnt = 0; mw_cnt = 0; sseq = '0;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Apply queued vectors; compare every cycle on the falling edge.
  task automatic run();
    vec_t v;
    out_t a, ex;
    while (q.size() > 0) begin
      v = q.pop_front();
      @(posedge clk); #1;
      reset = v.rst; Opcode = v.op; MemReady = v.mr; Zero = v.z;
      @(negedge clk);
      a = {State, ALUOp, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite, Reg2Loc,
           RegWrite, MemtoReg, PCSource, PCEn, InstrDone, Illegal, BusError};
      ex = v.e;
      cyc++;
      if (a.done && done_at == 0) done_at = cyc;
      if (a.berr && berr_at == 0) berr_at = cyc;
      ill_cnt += int'(a.ill); irw_cnt += int'(a.irw);
      rw_cnt += int'(a.rw); mw_cnt += int'(a.mwr);
      sseq = {sseq[27:0], a.st};
      if (!v.chk_st) begin
        a.st = '0; ex.st = '0;
      end
      nvec++;
      if (a !== ex) begin
        nbad++;
        $display("FAIL %s cycle %0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                 tag, cyc, a.st, a[17:0], ex.st, ex[17:0]);
      end
    end
  endtask

  initial begin
    vec_t v;
    int   keep;

    clr_stats("reset");
    q.push_back(rv(ADD, 1'b0));
    q.push_back(rv(ADD, 1'b1));
    run();

    clr_stats("add");
    add_instr(ADD, 1'b1, 0, 0);
    run();
    chk("add_len", done_at, 4);
    chk("add_states", int'(sseq), 32'h0000_0167);

    clr_stats("sub_and_orr");
    add_instr(SUB, 1'b0, 0, 0);
    add_instr(ANDI, 1'b0, 0, 0);
    add_instr(ORR, 1'b1, 1, 0);
    run();

    clr_stats("ldur_wait3");
    add_instr(LDUR, 1'b0, 0, 3);
    run();
    chk("ldur_len", done_at, 8);
    chk("ldur_states", int'(sseq), 32'h0123_3334);

    clr_stats("stur");
    add_instr(STUR, 1'b0, 0, 0);
    run();
    chk("stur_len", done_at, 4);

    clr_stats("cbz_taken");
    add_instr(CBZ, 1'b1, 0, 0);
    run();
    chk("cbz_len", done_at, 3);

    clr_stats("cbz_not_taken");
    add_instr(CBZ, 1'b0, 0, 0);
    run();

    clr_stats("b");
    add_instr(BR, 1'b0, 0, 0);
    run();
    chk("b_len", done_at, 3);

    clr_stats("illegal");
    add_instr(ILL, 1'b0, 0, 0);
    run();
    chk("ill_pulses", ill_cnt, 1);
    chk("ill_regwrite", rw_cnt + mw_cnt, 0);

    clr_stats("fetch_timeout");
    add_instr(ADD, 1'b0, 100, 0);
    add_instr(ADD, 1'b0, 0, 0);
    run();
    chk("fetch_to_cycle", berr_at, 15);
    chk("fetch_to_irwrite", irw_cnt, 1);

    clr_stats("fetch_ready_at_limit");
    add_instr(ADD, 1'b0, 14, 0);
    run();
    chk("fetch_limit_berr", berr_at, 0);
    chk("fetch_limit_len", done_at, 18);

    clr_stats("memrd_timeout");
    add_instr(LDUR, 1'b0, 0, 20);
    run();
    chk("memrd_to_cycle", berr_at, 18);
    chk("memrd_to_regwrite", rw_cnt, 0);

    clr_stats("memrd_ready_at_limit");
    add_instr(LDUR, 1'b0, 0, 14);
    run();
    chk("memrd_limit_len", done_at, 19);

    clr_stats("memwr_timeout_and_wait");
    add_instr(STUR, 1'b0, 0, 20);
    add_instr(STUR, 1'b1, 2, 2);
    run();

    clr_stats("reset_in_memwr");
    keep = q.size() + 4;
    add_instr(STUR, 1'b0, 0, 20);
    while (q.size() > keep) void'(q.pop_back());
    q.push_back(rv(STUR, 1'b0));
    add_instr(ADD, 1'b0, 0, 0);
    run();
    chk("reset_abort_len", done_at, 9);
    chk("reset_abort_memwrite", mw_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle LEGv8 datapath.
- It is the producer side of the ALUOp interface:
  - decodes the 11-bit instruction opcode;
  - sequences fetch/decode/execute/memory/writeback;
  - drives ALUOp and all datapath strobes.
- The ALU control block downstream turns ALUOp plus Opcode into the 4-bit ALU function code.
- Adds memory wait-state handling, a memory timeout and an illegal-opcode trap.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles waiting for MemReady in any memory state before BusError; 1..255.
- TO_W, 8: width of the wait counter.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Opcode  in  11  instruction bits [31:21] from the IR.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current read/write this cycle.
- ALUOp  out  2  00 = add (address/PC), 01 = branch/pass-B, 10 = R-format.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  load the IR.
- Reg2Loc  out  1  second register-read address from Rt.
- RegWrite  out  1  register file write.
- MemtoReg  out  1  writeback data from MDR.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = branch-unconditional target.
- PCEn  out  1  PC load enable; equals PCWrite OR (PCWriteCond AND Zero).
- InstrDone  out  1  one-cycle pulse when an instruction retires.
- Illegal  out  1  one-cycle pulse on an undecodable opcode.
- BusError  out  1  one-cycle pulse on memory timeout.
- State  out  4  current state encoding, for debug.

Behaviour:
Reset:
- While reset=1, all strobes are 0 (MemRead, MemWrite, IRWrite, RegWrite, PCEn, InstrDone, Illegal, BusError).
- ALUOp=00, all selects 0.
- At the reset edge: state=FETCH, wait counter=0.
- Reset mid-instruction aborts it; no partial writes occur after the edge.

Decode classes (DECODE state):
- R-format: Opcode = 10001011000 ADD, 11001011000 SUB, 10001010000 AND, 10101010000 ORR.
- LDUR: 11111000010.
- STUR: 11111000000.
- CBZ: Opcode[10:3] = 10110100.
- B: Opcode[10:5] = 000101.
- Anything else is illegal.

States (value; Moore outputs; transition). Unlisted outputs are 0.
- FETCH (0):
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCEn are asserted only in the cycle MemReady=1.
  - Next state: DECODE on MemReady.
- DECODE (1):
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut); Reg2Loc=1 for STUR/CBZ.
  - Next state by class: MEMADDR (LDUR/STUR), EXEC_R, CBZ_S, B_S.
  - Illegal opcode: pulse Illegal and go to FETCH.
- MEMADDR (2):
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=1 when STUR.
  - Next state: MEMRD for LDUR, MEMWR for STUR.
- MEMRD (3):
  - Outputs: MemRead=1, IorD=1.
  - Next state: MEMWB on MemReady.
- MEMWB (4):
  - Outputs: RegWrite=1, MemtoReg=1, InstrDone=1.
  - Next state: FETCH.
- MEMWR (5):
  - Outputs: MemWrite=1, IorD=1, Reg2Loc=1.
  - On MemReady: InstrDone=1 and go to FETCH.
- EXEC_R (6):
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Next state: RWB.
- RWB (7):
  - Outputs: RegWrite=1, MemtoReg=0, InstrDone=1.
  - Next state: FETCH.
- CBZ_S (8):
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCWriteCond=1, PCSource=01, InstrDone=1.
  - PCEn=Zero.
  - Next state: FETCH.
- B_S (9):
  - Outputs: PCEn=1, PCSource=10, InstrDone=1.
  - Next state: FETCH.

Wait counter:
- Cleared on every state change.
- Increments each cycle spent in FETCH/MEMRD/MEMWR with MemReady=0.
- When the counter equals MEM_TIMEOUT-1 and MemReady=0: pulse BusError and go to FETCH, with no IRWrite, RegWrite or PCEn.
- MemReady in the same cycle as the timeout wins: the access completes normally.

Other rules:
- Opcode is sampled only in DECODE and later states; it must be stable from the IR.
- Opcode changes outside those states are ignored.
- Cycle counts: R-format 4, CBZ/B 3, LDUR 5, STUR 4 (with MemReady=1 every cycle).

Decomposition:
- Shared package (legv8_pkg) holds:
  - state encodings;
  - opcode constants (ADD/SUB/AND/ORR/LDUR/STUR full 11-bit; CBZ 8-bit prefix; B 6-bit prefix);
  - ALUOp codes (00/01/10);
  - ALUSrcB and PCSource encodings.
- One natural sub-module: opcode_class_decode, a combinational map from Opcode to a one-hot class {R, LD, ST, CBZ, B, ILL}.

Test Plan:
- ADD (Opcode=10001011000), MemReady=1:
  - States 0→1→6→7→0.
  - ALUOp=10 in EXEC_R; RegWrite=1 and InstrDone=1 in cycle 4.
- LDUR (11111000010), MemReady low for 3 cycles in MEMRD:
  - Stays in state 3 for 4 cycles.
  - Then MEMWB with RegWrite=1, MemtoReg=1; total 8 cycles.
- CBZ (10110100101):
  - Zero=1 → PCEn=1, PCSource=01, ALUOp=01 in state 8.
  - Zero=0 → PCEn=0; InstrDone=1 in both cases.
- Opcode 01010101010 in DECODE:
  - Illegal pulses for 1 cycle; next state FETCH; no RegWrite/MemWrite.
- MemReady held 0 in FETCH, MEM_TIMEOUT=15:
  - BusError pulses in the 15th cycle, then FETCH restarts.
  - IRWrite never asserted.
- Reset asserted in MEMWR with MemReady=0:
  - MemWrite=0 in the reset cycle; State=0 after the edge.
  - The first post-reset cycle shows MemRead=1, IorD=0.
